// File: rtl/bp_core_lce_req_arbiter.sv
// Round-robin merge of the I$ (src 0) and D$ (src 1) LCE request streams onto one
// NoC request port; multi-beat messages hold the grant until their last beat.
module bp_core_lce_req_arbiter #(
  parameter int msg_width_p = 128,
  parameter int els_p       = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [1:0][msg_width_p-1:0] msg_i,
  input  logic [1:0]                  v_i,
  input  logic [1:0]                  last_i,
  output logic [1:0]                  ready_o,
  output logic [msg_width_p-1:0]      msg_o,
  output logic                        v_o,
  output logic                        last_o,
  output logic                        src_o,
  input  logic                        ready_i
);

  typedef struct packed {
    logic                   src;
    logic                   last;
    logic [msg_width_p-1:0] msg;
  } entry_s;

  entry_s     buf_q [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] cnt;
  logic       rr_ptr, lock_v, lock_src;
  logic       grant_v, grant_src;
  logic       full, enq, deq;
  logic [1:0] pend_q;

  always_comb begin
    grant_v   = 1'b0;
    grant_src = rr_ptr;
    if (lock_v) begin
      grant_v   = 1'b1;
      grant_src = lock_src;
    end else if (v_i == 2'b11) begin
      grant_v   = 1'b1;
      grant_src = rr_ptr;
    end else if (v_i[0]) begin
      grant_v   = 1'b1;
      grant_src = 1'b0;
    end else if (v_i[1]) begin
      grant_v   = 1'b1;
      grant_src = 1'b1;
    end
  end

  // No bypass: a full buffer refuses even when it drains this cycle, which also
  // keeps ready_i out of the ready_o cone.
  assign full = (cnt == 2'd2);

  for (genvar s = 0; s < 2; s++) begin : g_rdy
    assign ready_o[s] = ~reset_i & ~full & grant_v & (grant_src == 1'(s)) & v_i[s];
  end

  assign enq    = |ready_o;
  assign v_o    = ~reset_i & (cnt != 2'd0);
  assign deq    = v_o & ready_i;
  assign msg_o  = buf_q[rd_ptr].msg;
  assign last_o = buf_q[rd_ptr].last;
  assign src_o  = buf_q[rd_ptr].src;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr   <= 1'b0;
      lock_v   <= 1'b0;
      lock_src <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      cnt      <= 2'd0;
      pend_q   <= 2'b00;
    end else begin
      if (enq) begin
        wr_ptr <= ~wr_ptr;
        if (last_i[grant_src]) begin
          lock_v <= 1'b0;
          rr_ptr <= ~grant_src;
        end else begin
          lock_v   <= 1'b1;
          lock_src <= grant_src;
        end
      end
      if (deq) rd_ptr <= ~rd_ptr;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      pend_q <= v_i & ~ready_o;
    end
  end

  // Payload storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (!reset_i && enq)
      buf_q[wr_ptr] <= '{src: grant_src, last: last_i[grant_src], msg: msg_i[grant_src]};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (cnt <= 2'd2);
      assert (!(enq && full));
      assert (!(deq && cnt == 2'd0));
      for (int s = 0; s < 2; s++)
        assert (!(pend_q[s] && !v_i[s]));
    end
  end

endmodule

// File: tb/tb_bp_core_lce_req_arbiter.sv
// Directed bench for bp_core_lce_req_arbiter: reset, alternation, atomicity,
// backpressure, simultaneous enqueue/dequeue, and reset mid-message.
module tb_bp_core_lce_req_arbiter;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [1:0][127:0] msg_i;
  logic [1:0]        v_i, last_i, ready_o;
  logic [127:0]      msg_o;
  logic              v_o, last_o, src_o, ready_i;
  int                vectors = 0;
  int                miscompares = 0;

  always #5 clk = ~clk;

  bp_core_lce_req_arbiter #(.msg_width_p(128), .els_p(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .msg_i(msg_i), .v_i(v_i), .last_i(last_i),
    .ready_o(ready_o), .msg_o(msg_o), .v_o(v_o), .last_o(last_o), .src_o(src_o),
    .ready_i(ready_i)
  );

  localparam logic [127:0] A0 = 128'hA0, A1 = 128'hA1, A2 = 128'hA2, A3 = 128'hA3;
  localparam logic [127:0] B0 = 128'hB0, B1 = 128'hB1, B2 = 128'hB2;
  localparam logic [127:0] C0 = 128'hC0, C1 = 128'hC1, C2 = 128'hC2;
  localparam logic [127:0] D0 = 128'hD0, D1 = 128'hD1, D2 = 128'hD2;
  localparam logic [127:0] E0 = 128'hE0, F0 = 128'hF0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic drive(input logic rst, input logic [1:0] v, input logic [1:0] last,
                       input logic [127:0] m0, input logic [127:0] m1, input logic rdy);
    @(posedge clk);
    #1;
    reset_i  = rst;
    v_i      = v;
    last_i   = last;
    msg_i[0] = m0;
    msg_i[1] = m1;
    ready_i  = rdy;
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] r, input logic v,
                            input logic s, input logic l, input logic [127:0] m);
    chk({tag, ".ready_o"}, 128'(ready_o), 128'(r));
    chk({tag, ".v_o"}, 128'(v_o), 128'(v));
    if (v) begin
      chk({tag, ".src_o"}, 128'(src_o), 128'(s));
      chk({tag, ".last_o"}, 128'(last_o), 128'(l));
      chk({tag, ".msg_o"}, msg_o, m);
    end
  endtask

  initial begin
    reset_i = 1'b1; v_i = 2'b11; last_i = 2'b11;
    msg_i[0] = A0; msg_i[1] = B0; ready_i = 1'b0;

    // reset held 3 cycles with both sources valid
    drive(1, 2'b11, 2'b11, A0, B0, 0); expect_out("rst0", 2'b00, 0, 0, 0, 0);
    drive(1, 2'b11, 2'b11, A0, B0, 0); expect_out("rst1", 2'b00, 0, 0, 0, 0);
    drive(1, 2'b11, 2'b11, A0, B0, 0); expect_out("rst2", 2'b00, 0, 0, 0, 0);
    drive(0, 2'b11, 2'b11, A0, B0, 1); expect_out("post_rst", 2'b01, 0, 0, 0, 0);

    // alternation of single-beat messages
    drive(0, 2'b11, 2'b11, A1, B1, 1); expect_out("alt1", 2'b10, 1, 0, 1, A0);
    drive(0, 2'b11, 2'b11, A1, B2, 1); expect_out("alt2", 2'b01, 1, 1, 1, B1);
    drive(0, 2'b11, 2'b11, A2, B2, 1); expect_out("alt3", 2'b10, 1, 0, 1, A1);
    drive(0, 2'b11, 2'b01, A2, C0, 1); expect_out("alt4", 2'b01, 1, 1, 1, B2);

    // src1 3-beat message holds the grant, including a gap cycle
    drive(0, 2'b11, 2'b01, A3, C0, 1); expect_out("atom1", 2'b10, 1, 0, 1, A2);
    drive(0, 2'b11, 2'b01, A3, C1, 1); expect_out("atom2", 2'b10, 1, 1, 0, C0);
    drive(0, 2'b01, 2'b01, A3, C1, 1); expect_out("atom_gap", 2'b00, 1, 1, 0, C1);
    drive(0, 2'b11, 2'b11, A3, C2, 1); expect_out("atom3", 2'b10, 0, 0, 0, 0);
    drive(0, 2'b01, 2'b11, A3, C2, 1); expect_out("atom_rel", 2'b01, 1, 1, 1, C2);

    // backpressure: two beats fill the buffer, no bypass on dequeue
    drive(0, 2'b01, 2'b11, D0, C2, 0); expect_out("bp0", 2'b01, 1, 0, 1, A3);
    drive(0, 2'b01, 2'b11, D1, C2, 0); expect_out("bp_full", 2'b00, 1, 0, 1, A3);
    drive(0, 2'b01, 2'b11, D1, C2, 1); expect_out("bp_deq", 2'b00, 1, 0, 1, A3);
    drive(0, 2'b01, 2'b11, D1, C2, 0); expect_out("bp_resume", 2'b01, 1, 0, 1, D0);
    drive(0, 2'b00, 2'b11, D1, C2, 1); expect_out("bp_drain", 2'b00, 1, 0, 1, D0);

    // enqueue and dequeue together at occupancy 1
    drive(0, 2'b01, 2'b11, D2, C2, 1); expect_out("sim_eq", 2'b01, 1, 0, 1, D1);
    drive(0, 2'b00, 2'b11, D2, C2, 0); expect_out("sim_hold", 2'b00, 1, 0, 1, D2);
    drive(0, 2'b00, 2'b11, D2, C2, 1); expect_out("sim_last", 2'b00, 1, 0, 1, D2);

    // reset after first beat of a 2-beat src0 message
    drive(0, 2'b01, 2'b10, E0, C2, 1); expect_out("mid_beat1", 2'b01, 0, 0, 0, 0);
    drive(1, 2'b00, 2'b10, E0, C2, 0); expect_out("mid_rst", 2'b00, 0, 0, 0, 0);
    drive(0, 2'b10, 2'b11, E0, F0, 1); expect_out("mid_after", 2'b10, 0, 0, 0, 0);
    drive(0, 2'b00, 2'b11, E0, F0, 1); expect_out("mid_out", 2'b00, 1, 1, 1, F0);
    drive(0, 2'b00, 2'b11, E0, F0, 1); expect_out("mid_empty", 2'b00, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
